// File: rtl/counter_param.sv
// Parametrised up/down counter with prescaler, wrap/saturate modes,
// terminal-count pulse and sticky overflow flag.
module counter_param #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int PRESCALE = 1,
  parameter int RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat_mode,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C   = WIDTH'(RST_VAL);
  localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_TOP = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             bound;

  // Prescaler is a down-counter: PRE_TOP means no enabled cycles elapsed yet,
  // and a step is taken on the enabled cycle where it has reached zero.
  always_comb begin
    cnt_d   = cnt_q;
    presc_d = presc_q;
    step    = 1'b0;
    bound   = 1'b0;
    ovf_d   = ovf_q;

    if (clr) begin
      cnt_d   = RST_C;
      presc_d = PRE_TOP;
    end else if (load) begin
      cnt_d   = (load_val > MAX_C) ? MAX_C : load_val;
      presc_d = PRE_TOP;
    end else if (en) begin
      if (presc_q == '0) begin
        presc_d = PRE_TOP;
        step    = 1'b1;
      end else begin
        presc_d = presc_q - 1'b1;
      end
    end

    if (step) begin
      if (dir) begin
        if (cnt_q == MAX_C) begin
          bound = 1'b1;
          if (!sat_mode) cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          bound = 1'b1;
          if (!sat_mode) cnt_d = MAX_C;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end

    // A boundary step in the same cycle as ovf_clr leaves the flag set.
    if (ovf_clr) ovf_d = 1'b0;
    if (bound)   ovf_d = 1'b1;
    tc_d = bound;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= RST_C;
      presc_q <= PRE_TOP;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out    = cnt_q;
  assign tc     = tc_q;
  assign ovf    = ovf_q;
  assign at_max = (cnt_q == MAX_C);
  assign at_min = (cnt_q == '0);

endmodule
